mc_controller: RTL and testbench

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_controller.sv | 213 +++++++++++++++++++++
 tb/tb_mc_controller.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// Multicycle MIPS-style control FSM (Moore). Outputs are decoded from the state;
// op and funct can also affect them in DECODE and EXECUTE, and zero can affect
// them in BRANCH.
// Optional feature macro: EXT_ALU_OPS_EN enables ROR/ROL/NOR/MUL decode and the
// two-cycle MUL stretch in EXECUTE.
module mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [3:0] alucontrol,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic       illegal
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t     state;
    // lw/sw choice captured in DECODE so op is not looked at in MEMADR
    logic       is_store;
    logic       f_ok;
    logic [3:0] f_alu;
`ifdef EXT_ALU_OPS_EN
    logic       f_mul;
    logic       stretch;
`endif

    // R-type function field decode
    always_comb begin
        f_ok  = 1'b1;
        f_alu = 4'b0000;
`ifdef EXT_ALU_OPS_EN
        f_mul = 1'b0;
`endif
        case (funct)
            6'b100100: f_alu = 4'b0000;
            6'b100101: f_alu = 4'b0001;
            6'b100000: f_alu = 4'b0010;
            6'b100010: f_alu = 4'b1010;
            6'b101010: f_alu = 4'b1011;
`ifdef EXT_ALU_OPS_EN
            6'b000100: f_alu = 4'b0100;
            6'b000110: f_alu = 4'b0101;
            6'b100111: f_alu = 4'b0110;
            6'b100110: begin
                f_alu = 4'b0111;
                f_mul = 1'b1;
            end
`endif
            default: begin
                f_ok  = 1'b0;
                f_alu = 4'b0000;
            end
        endcase
    end

    // State register with next-state sequencing
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= FETCH;
            is_store <= 1'b0;
`ifdef EXT_ALU_OPS_EN
            stretch  <= 1'b0;
`endif
        end else begin
`ifdef EXT_ALU_OPS_EN
            stretch <= 1'b0;
`endif
            case (state)
                FETCH:  state <= DECODE;
                DECODE: begin
                    is_store <= (op == OP_SW);
                    case (op)
                        OP_LW, OP_SW: state <= MEMADR;
                        OP_RTYPE:     state <= EXECUTE;
                        OP_BEQ:       state <= BRANCH;
                        OP_ADDI:      state <= ADDIEX;
                        OP_J:         state <= JUMP;
                        default:      state <= FETCH;
                    endcase
                end
                MEMADR: state <= is_store ? MEMWR : MEMRD;
                MEMRD:  state <= MEMWB;
                MEMWB:  state <= FETCH;
                MEMWR:  state <= FETCH;
                EXECUTE: begin
                    if (!f_ok) begin
                        state <= FETCH;
                    end
`ifdef EXT_ALU_OPS_EN
                    else if (f_mul && !stretch) begin
                        stretch <= 1'b1;
                    end
`endif
                    else begin
                        state <= ALUWB;
                    end
                end
                ALUWB:  state <= FETCH;
                BRANCH: state <= FETCH;
                ADDIEX: state <= ADDIWB;
                ADDIWB: state <= FETCH;
                JUMP:   state <= FETCH;
                default: state <= FETCH;
            endcase
        end
    end

    // Output decode from state (Moore), all strobes default low
    always_comb begin
        alucontrol = 4'b0000;
        iord       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        pcen       = 1'b0;
        illegal    = 1'b0;
        case (state)
            FETCH: begin
                irwrite    = 1'b1;
                pcen       = 1'b1;
                alusrcb    = 2'b01;
                alucontrol = 4'b0010;
            end
            DECODE: begin
                alusrcb    = 2'b11;
                alucontrol = 4'b0010;
                case (op)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: illegal = 1'b0;
                    default: illegal = 1'b1;
                endcase
            end
            MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = 4'b0010;
            end
            MEMRD: iord = 1'b1;
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            EXECUTE: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b00;
                alucontrol = f_alu;
                illegal    = !f_ok;
            end
            ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            BRANCH: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b00;
                alucontrol = 4'b1010;
                pcsrc      = 2'b01;
                pcen       = zero;
            end
            ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = 4'b0010;
            end
            ADDIWB: regwrite = 1'b1;
            JUMP: begin
                pcsrc = 2'b10;
                pcen  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_controller.sv
// Randomized self-checking bench for mc_controller. The reference model
// describes each instruction as a timeline of expected output vectors.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic [3:0] alucontrol;
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic       pcen, illegal;

    int n_cmp = 0;
    int n_bad = 0;

    mc_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .alucontrol(alucontrol), .iord(iord), .memwrite(memwrite),
        .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg),
        .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
        .pcsrc(pcsrc), .pcen(pcen), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Output vector {alu, iord, mw, irw, rd, mtr, rw, asa, asb, pcs, pcen, ill}
    function automatic logic [16:0] mk(input logic [3:0] alu, input logic io, input logic mw,
                                       input logic irw, input logic rd, input logic mtr,
                                       input logic rw, input logic asa, input logic [1:0] asb,
                                       input logic [1:0] pcs, input logic pe, input logic ill);
        return {alu, io, mw, irw, rd, mtr, rw, asa, asb, pcs, pe, ill};
    endfunction

    function automatic logic [16:0] dut_vec();
        return {alucontrol, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
                alusrca, alusrcb, pcsrc, pcen, illegal};
    endfunction

    localparam logic [16:0] V_FETCH = 17'b0010_0010000_01_00_1_0;

    // ALU function table: {valid, code}
    function automatic logic [4:0] fdec(input logic [5:0] f);
        case (f)
            6'b100100: return 5'b1_0000;
            6'b100101: return 5'b1_0001;
            6'b100000: return 5'b1_0010;
            6'b100010: return 5'b1_1010;
            6'b101010: return 5'b1_1011;
`ifdef EXT_ALU_OPS_EN
            6'b000100: return 5'b1_0100;
            6'b000110: return 5'b1_0101;
            6'b100111: return 5'b1_0110;
            6'b100110: return 5'b1_0111;
`endif
            default:   return 5'b0_0000;
        endcase
    endfunction

    function automatic int mul_extra(input logic [5:0] f);
`ifdef EXT_ALU_OPS_EN
        return (f == 6'b100110) ? 1 : 0;
`else
        return (f == 6'b100110) ? 0 : 0;
`endif
    endfunction

    function automatic bit op_legal(input logic [5:0] o);
        return o inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    endfunction

    // Total cycles of an instruction, FETCH included
    function automatic int ilen(input logic [5:0] o, input logic [5:0] f);
        case (o)
            6'b100011: return 5;
            6'b101011: return 4;
            6'b000000: begin
                logic [4:0] d;
                d = fdec(f);
                return d[4] ? 4 + mul_extra(f) : 3;
            end
            6'b000100: return 3;
            6'b001000: return 4;
            6'b000010: return 3;
            default:   return 2;
        endcase
    endfunction

    // Expected outputs for cycle k of instruction (o,f) with this cycle's zero
    function automatic logic [16:0] expv(input logic [5:0] o, input logic [5:0] f,
                                         input int k, input logic z);
        logic [4:0] d;
        d = fdec(f);
        if (k == 0) return V_FETCH;
        if (k == 1) return mk(4'b0010, 0,0,0,0,0,0,0, 2'b11, 2'b00, 0, !op_legal(o));
        case (o)
            6'b100011, 6'b101011: begin
                if (k == 2) return mk(4'b0010, 0,0,0,0,0,0,1, 2'b10, 2'b00, 0, 0);
                if (o == 6'b101011) return mk(4'b0000, 1,1,0,0,0,0,0, 2'b00, 2'b00, 0, 0);
                if (k == 3) return mk(4'b0000, 1,0,0,0,0,0,0, 2'b00, 2'b00, 0, 0);
                return mk(4'b0000, 0,0,0,0,1,1,0, 2'b00, 2'b00, 0, 0);
            end
            6'b000000: begin
                if (!d[4]) return mk(4'b0000, 0,0,0,0,0,0,1, 2'b00, 2'b00, 0, 1);
                if (k <= 2 + mul_extra(f)) return mk(d[3:0], 0,0,0,0,0,0,1, 2'b00, 2'b00, 0, 0);
                return mk(4'b0000, 0,0,0,1,0,1,0, 2'b00, 2'b00, 0, 0);
            end
            6'b000100: return mk(4'b1010, 0,0,0,0,0,0,1, 2'b00, 2'b01, z, 0);
            6'b001000: begin
                if (k == 2) return mk(4'b0010, 0,0,0,0,0,0,1, 2'b10, 2'b00, 0, 0);
                return mk(4'b0000, 0,0,0,0,0,1,0, 2'b00, 2'b00, 0, 0);
            end
            default: return mk(4'b0000, 0,0,0,0,0,0,0, 2'b00, 2'b10, 1, 0);
        endcase
    endfunction

    // Run one instruction; abort_at >= 0 asserts reset during that cycle
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int abort_at);
        int n;
        int last_exec;
        n = ilen(o, f);
        last_exec = 2 + mul_extra(f);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            zero  = 1'($urandom);
            op    = (k == 1) ? o : 6'($urandom);
            funct = (o == 6'b000000 && k >= 2 && k <= last_exec) ? f : 6'($urandom);
            if (k == abort_at) begin
                reset = 1'b1;
                #1;
                check("rst_async", 32'(dut_vec()), 32'(V_FETCH));
                @(negedge clk);
                op = 6'($urandom);
                #1;
                check("rst_hold", 32'(dut_vec()), 32'(V_FETCH));
                @(posedge clk);
                #1 reset = 1'b0;
                return;
            end
            #1;
            check($sformatf("op%b_f%b_k%0d", o, f, k), 32'(dut_vec()), 32'(expv(o, f, k, zero)));
            check("excl", 32'(int'(irwrite) + int'(memwrite) + int'(regwrite) <= 1), 32'd1);
        end
    endtask

    logic [5:0] ftab [10];
    logic [5:0] ro, rf;
    int         sel, ab;

    initial begin
        ftab = '{6'b100100, 6'b100101, 6'b100000, 6'b100010, 6'b101010,
                 6'b000100, 6'b000110, 6'b100111, 6'b100110, 6'b111111};

        // Reset state
        repeat (2) @(negedge clk);
        #1 check("reset_state", 32'(dut_vec()), 32'(V_FETCH));
        @(posedge clk);
        #1 reset = 1'b0;

        // Directed instructions
        run_instr(6'b100011, 6'd0, -1);
        run_instr(6'b101011, 6'd0, -1);
        for (int i = 0; i < 10; i++) run_instr(6'b000000, ftab[i], -1);
        for (int i = 0; i < 4; i++) run_instr(6'b000100, 6'd0, -1);
        run_instr(6'b001000, 6'd0, -1);
        run_instr(6'b000010, 6'd0, -1);
        run_instr(6'b111111, 6'd0, -1);
        // Reset mid-MEMRD, mid-MUL stretch, then a full MUL afterwards
        run_instr(6'b100011, 6'd0, 3);
        run_instr(6'b000000, 6'b100110, 2);
        run_instr(6'b000000, 6'b100110, 3);
        run_instr(6'b000000, 6'b100110, -1);

        // Random instruction stream
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 9);
            rf  = ftab[$urandom_range(0, 9)];
            if ($urandom_range(0, 7) == 0) rf = 6'($urandom);
            case (sel)
                0: ro = 6'b100011;
                1: ro = 6'b101011;
                2, 3, 4: ro = 6'b000000;
                5: ro = 6'b000100;
                6: ro = 6'b001000;
                7: ro = 6'b000010;
                8: ro = 6'($urandom);
                default: ro = 6'b111111;
            endcase
            ab = -1;
            if ($urandom_range(0, 9) == 0) ab = $urandom_range(0, ilen(ro, rf) - 1);
            run_instr(ro, rf, ab);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
